fp_unit_seq: RTL and testbench
==============================

Name: fp_unit_seq

Overview:
Multicycle IEEE-754-style floating-point unit that performs add, subtract and multiply on two operands. It uses a start/busy/done handshake and holds its result after completion. It replaces the single-cycle add/multiply datapath with an FSM-sequenced datapath that has aligning, normalising and rounding stages. Exponent and fraction widths are parametrised, so the same block serves binary32 and narrower or wider formats.

Parameters:
EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
FRAC_W, 23, stored fraction width (hidden bit is implicit)

Ports:
clk  input  1  clock; all logic is on the rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin an operation; sampled only in IDLE
op  input  2  00 add, 01 subtract (a-b), 10 multiply, 11 reserved (treated as add)
a  input  1+EXP_W+FRAC_W  operand A as {sign, exp, frac}
b  input  1+EXP_W+FRAC_W  operand B
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when result becomes valid
result  output  1+EXP_W+FRAC_W  final value; held until the next done
overflow  output  1  result saturated to infinity; valid with done, held
underflow  output  1  result flushed to zero; valid with done, held

Behaviour:
- Reset (synchronous, active-high): state=IDLE, busy=0, done=0, result=0, overflow=0, underflow=0. Reset asserted mid-operation aborts it: no done pulse is produced and the partial result is discarded.
- FSM states: IDLE, UNPACK, ALIGN, MUL, ADD, NORM, ROUND, FINISH.
- IDLE: when start=1, latch a, b and op, then go to UNPACK. start is ignored while busy=1.
- UNPACK (1 cycle): an operand with exp=0 is zero (subnormals are flushed). A zero operand forces the result to zero and the FSM jumps to FINISH. Mantissa = {1, frac, 3'b000}, which adds guard, round and sticky bits. For subtract, invert the sign of b. Add/subtract then goes to ALIGN; multiply goes to MUL.
- ALIGN (1 cycle): barrel right-shift the smaller-exponent mantissa by the exponent difference. Bits shifted out are ORed into sticky. If the difference is greater than FRAC_W+3, the mantissa becomes sticky-only.
- ADD (1 cycle): equal signs add magnitudes. Opposite signs subtract the smaller magnitude from the larger, and the result takes the sign of the larger. An exact zero difference gives +0 and goes to FINISH.
- MUL: shift-add over FRAC_W+1 cycles, one multiplier bit per cycle. Product width is 2*(FRAC_W+1). Result exponent = ea+eb-bias. Sign = sa^sb. Low product bits collapse to guard/round/sticky.
- NORM: a carry-out (add) or product MSB in the upper position triggers one right shift and exp+1 in a single cycle. Otherwise left-shift one bit per cycle and decrement exp until the hidden bit = 1. Normalisation takes at most FRAC_W+3 cycles.
- ROUND (1 cycle): round-to-nearest-even. Increment when guard=1 and (round|sticky|lsb). A mantissa carry from rounding shifts right once and increments exp.
- Exponent checks, applied after rounding:
  - exp >= 2^EXP_W-1: result = {sign, all-ones, 0}, overflow=1.
  - exp <= 0 (signed): result = {sign, 0, 0}, underflow=1.
- Input exp all-ones is treated as infinity: result = inf with overflow=1. No NaN generation; inf-inf also returns +inf with overflow=1.
- FINISH: drive result and flags, pulse done for 1 cycle, clear busy, return to IDLE. A new start can be accepted in the cycle after done.
- Latency from start to done:
  - zero operand: 3 cycles
  - add/sub: 6 cycles plus normalisation shifts
  - mul: FRAC_W+6 cycles
- Internal exponent arithmetic is signed, EXP_W+2 bits wide, so no wrap-around can occur before the range checks.

Test Plan:
- Add: a=0x3F800000, b=0x3F800000, op=00 -> result 0x40000000; overflow=0, underflow=0; done pulses once with busy low in the same cycle.
- Multiply: a=0x3FC00000, b=0x40000000, op=10 -> result 0x40400000 after exactly 29 cycles (FRAC_W=23).
- Subtract with cancellation: 0x40400000 - 0x3F800000 -> 0x40000000. 0x3F800000 - 0x3F800000 -> 0x00000000 (+0).
- Rounding: 0x3F800000 + 0x33800000 -> 0x3F800000 (tie, round to even). 0x3F800000 + 0x33C00000 -> 0x3F800001.
- Range: 0x7F000000 * 0x7F000000 -> 0x7F800000 with overflow=1. 0x00800000 * 0x00800000 -> 0x00000000 with underflow=1.
- Control: pulse start again while busy -> ignored and only one done is produced. Assert reset for 1 cycle mid-multiply -> busy=0, done stays 0, result=0; a following add then completes normally.

Source files
------------

// File: rtl/fp_unit_seq.sv
// Multicycle floating-point add/sub/mul unit with start/busy/done handshake.
// Sequenced datapath: unpack, align, add or shift-add multiply, normalise, round.
module fp_unit_seq #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [1:0]              op,
  input  logic [EXP_W+FRAC_W:0]   a,
  input  logic [EXP_W+FRAC_W:0]   b,
  output logic                    busy,
  output logic                    done,
  output logic [EXP_W+FRAC_W:0]   result,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int DW  = 1 + EXP_W + FRAC_W;
  localparam int EW2 = EXP_W + 2;
  localparam int M   = FRAC_W + 4;
  localparam int W   = FRAC_W + 5;
  localparam int PW  = 2 * (FRAC_W + 1);
  localparam int CW  = $clog2(FRAC_W + 1) + 1;
  localparam logic signed [EW2-1:0] BIAS = EW2'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW2-1:0] EMAX = EW2'((1 << EXP_W) - 1);
  localparam logic [15:0] MAXSH = 16'(M);

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_MUL,
    S_ADD, S_NORM, S_ROUND, S_FINISH
  } state_t;

  state_t r_state, w_nxt;

  logic [DW-1:0]           r_a, r_b, r_res, r_result;
  logic [1:0]              r_op;
  logic                    r_sa, r_sb, r_s;
  logic [EXP_W-1:0]        r_ea, r_eb;
  logic [M-1:0]            r_ma, r_mb;
  logic [W-1:0]            r_m;
  logic signed [EW2-1:0]   r_e;
  logic [PW-1:0]           r_p;
  logic [CW-1:0]           r_cnt;
  logic                    r_ovf, r_unf;
  logic                    r_overflow, r_underflow;
  logic                    r_done, r_busy;

  // Unpack / special operands
  logic [EXP_W-1:0] w_ea, w_eb;
  logic w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic w_sb, w_mul, w_inf_s;

  assign w_ea     = r_a[DW-2:FRAC_W];
  assign w_eb     = r_b[DW-2:FRAC_W];
  assign w_a_inf  = &w_ea;
  assign w_b_inf  = &w_eb;
  assign w_a_zero = ~|w_ea;
  assign w_b_zero = ~|w_eb;
  assign w_sb     = r_b[DW-1] ^ (r_op == 2'b01);
  assign w_mul    = (r_op == 2'b10);
  assign w_inf_s  = w_mul ? (r_a[DW-1] ^ r_b[DW-1]) :
                    (w_a_inf && w_b_inf && (r_a[DW-1] != w_sb)) ? 1'b0 :
                    w_a_inf ? r_a[DW-1] : w_sb;

  // Align: shift the smaller operand, shifted-out bits fold into sticky
  logic             w_age;
  logic [EXP_W-1:0] w_d;
  logic [15:0]      w_dx, w_dc;
  logic [M-1:0]     w_sm, w_msk, w_shf;

  assign w_age = (r_ea >= r_eb);
  assign w_d   = w_age ? (r_ea - r_eb) : (r_eb - r_ea);
  assign w_dx  = 16'(w_d);
  assign w_dc  = (w_dx > MAXSH) ? MAXSH : w_dx;
  assign w_sm  = w_age ? r_mb : r_ma;
  assign w_msk = ~({M{1'b1}} << w_dc);
  assign w_shf = (w_sm >> w_dc) | M'(|(w_sm & w_msk));

  // Magnitude add/subtract
  logic         w_mgt;
  logic [W-1:0] w_sum, w_dif, w_am;
  logic         w_as;

  assign w_mgt = (r_ma >= r_mb);
  assign w_sum = {1'b0, r_ma} + {1'b0, r_mb};
  assign w_dif = w_mgt ? {1'b0, r_ma - r_mb} : {1'b0, r_mb - r_ma};
  assign w_am  = (r_sa == r_sb) ? w_sum : w_dif;
  assign w_as  = (r_sa == r_sb) ? r_sa : (w_mgt ? r_sa : r_sb);

  // Shift-add multiply: multiplier sits in the low half of r_p
  logic [FRAC_W+1:0] w_hi;
  logic [PW-1:0]     w_pn;
  logic [W-1:0]      w_pm;

  assign w_hi = {1'b0, r_p[PW-1:FRAC_W+1]} +
                (r_p[0] ? {1'b0, r_ma[M-1:3]} : '0);
  assign w_pn = {w_hi, r_p[FRAC_W:1]};
  assign w_pm = {w_pn[PW-1:FRAC_W-2], |w_pn[FRAC_W-3:0]};

  // Round to nearest even and range checks
  logic                  w_inc, w_rc, w_ov, w_un;
  logic [FRAC_W+1:0]     w_mr;
  logic [FRAC_W-1:0]     w_fr;
  logic signed [EW2-1:0] w_ef;

  assign w_inc = r_m[2] & (r_m[1] | r_m[0] | r_m[3]);
  assign w_mr  = {1'b0, r_m[W-2:3]} + (FRAC_W+2)'(w_inc);
  assign w_rc  = w_mr[FRAC_W+1];
  assign w_fr  = w_rc ? w_mr[FRAC_W:1] : w_mr[FRAC_W-1:0];
  assign w_ef  = r_e + EW2'(w_rc);
  assign w_ov  = (w_ef >= EMAX);
  assign w_un  = w_ef[EW2-1] | (w_ef == '0);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_nxt = S_UNPACK;
      S_UNPACK: begin
        if (w_a_inf | w_b_inf | w_a_zero | w_b_zero) w_nxt = S_FINISH;
        else if (w_mul)                              w_nxt = S_MUL;
        else                                         w_nxt = S_ALIGN;
      end
      S_ALIGN:  w_nxt = S_ADD;
      S_MUL:    if (r_cnt == CW'(FRAC_W)) w_nxt = S_NORM;
      S_ADD: begin
        if (w_am == '0)                    w_nxt = S_FINISH;
        else if (w_am[W-1] | ~w_am[W-2])   w_nxt = S_NORM;
        else                               w_nxt = S_ROUND;
      end
      // leave once this cycle's shift lands the hidden bit
      S_NORM:   if (r_m[W-1] | r_m[W-2] | r_m[W-3]) w_nxt = S_ROUND;
      S_ROUND:  w_nxt = S_FINISH;
      S_FINISH: w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a <= '0; r_b <= '0; r_op <= '0;
      r_sa <= 1'b0; r_sb <= 1'b0; r_s <= 1'b0;
      r_ea <= '0; r_eb <= '0;
      r_ma <= '0; r_mb <= '0; r_m <= '0;
      r_e <= '0; r_p <= '0; r_cnt <= '0;
      r_res <= '0; r_ovf <= 1'b0; r_unf <= 1'b0;
      r_result <= '0; r_overflow <= 1'b0; r_underflow <= 1'b0;
      r_done <= 1'b0; r_busy <= 1'b0;
    end else begin
      r_done <= (r_state == S_FINISH);
      r_busy <= (w_nxt != S_IDLE);
      unique case (r_state)
        S_IDLE: if (start) begin
          r_a  <= a;
          r_b  <= b;
          r_op <= op;
        end
        S_UNPACK: begin
          r_sa  <= r_a[DW-1];
          r_sb  <= w_sb;
          r_ea  <= w_ea;
          r_eb  <= w_eb;
          r_ma  <= {1'b1, r_a[FRAC_W-1:0], 3'b000};
          r_mb  <= {1'b1, r_b[FRAC_W-1:0], 3'b000};
          r_s   <= r_a[DW-1] ^ r_b[DW-1];
          r_e   <= $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - BIAS;
          r_p   <= {{(FRAC_W+1){1'b0}}, 1'b1, r_b[FRAC_W-1:0]};
          r_cnt <= '0;
          r_ovf <= w_a_inf | w_b_inf;
          r_unf <= 1'b0;
          if (w_a_inf | w_b_inf)
            r_res <= {w_inf_s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          else
            r_res <= '0;
        end
        S_ALIGN: begin
          if (w_age) begin
            r_mb <= w_shf;
            r_e  <= {2'b00, r_ea};
          end else begin
            r_ma <= w_shf;
            r_e  <= {2'b00, r_eb};
          end
        end
        S_MUL: begin
          r_p   <= w_pn;
          r_m   <= w_pm;
          r_cnt <= r_cnt + CW'(1);
        end
        S_ADD: begin
          r_m <= w_am;
          r_s <= w_as;
        end
        S_NORM: begin
          if (r_m[W-1]) begin
            r_m <= {1'b0, r_m[W-1:2], r_m[1] | r_m[0]};
            r_e <= r_e + EW2'(1);
          end else if (!r_m[W-2]) begin
            r_m <= r_m << 1;
            r_e <= r_e - EW2'(1);
          end
        end
        S_ROUND: begin
          r_ovf <= w_ov;
          r_unf <= ~w_ov & w_un;
          if (w_ov)
            r_res <= {r_s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          else if (w_un)
            r_res <= {r_s, {EXP_W{1'b0}}, {FRAC_W{1'b0}}};
          else
            r_res <= {r_s, w_ef[EXP_W-1:0], w_fr};
        end
        S_FINISH: begin
          r_result    <= r_res;
          r_overflow  <= r_ovf;
          r_underflow <= r_unf;
        end
        default: ;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_fp_unit_seq.sv
// Directed-vector bench for fp_unit_seq in binary32 configuration.
// Expected values are hand-computed IEEE-754 encodings.
module tb_fp_unit_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, overflow, underflow;
  logic [31:0] result;

  fp_unit_seq #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .done(done),
    .result(result), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  int   lat;
  logic bz1, bzd;

  // Pulse start, wait for done; optionally re-pulse start at cycle inj.
  task automatic run(input logic [1:0] o, input logic [31:0] av,
                     input logic [31:0] bv, input int inj,
                     output int l, output logic b1, output logic bd);
    @(posedge clk); #1;
    op = o; a = av; b = bv; start = 1'b1;
    l = 0; b1 = 1'b0; bd = 1'b1;
    repeat (200) begin
      @(posedge clk); #1;
      l++;
      if (l == 1) begin start = 1'b0; b1 = busy; end
      if (inj != 0 && l == inj) begin
        start = 1'b1; op = 2'b00;
        a = 32'h3F80_0000; b = 32'h3F80_0000;
      end
      if (inj != 0 && l == inj + 1) start = 1'b0;
      if (done) begin bd = busy; break; end
    end
    if (!done) check("timeout", 32'd0, 32'd1);
  endtask

  task automatic count_done(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (done) c++;
    end
  endtask

  int nd;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_res", result, 32'h0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_unf", 32'(underflow), 32'd0);
    reset = 1'b0;

    run(2'b00, 32'h3F80_0000, 32'h3F80_0000, 0, lat, bz1, bzd);
    check("add_res", result, 32'h4000_0000);
    check("add_ovf", 32'(overflow), 32'd0);
    check("add_unf", 32'(underflow), 32'd0);
    check("add_lat", 32'(lat), 32'd7);
    check("add_busy1", 32'(bz1), 32'd1);
    check("add_busyd", 32'(bzd), 32'd0);
    count_done(3, nd);
    check("add_once", 32'(nd), 32'd0);

    run(2'b10, 32'h3FC0_0000, 32'h4000_0000, 0, lat, bz1, bzd);
    check("mul_res", result, 32'h4040_0000);
    check("mul_lat", 32'(lat), 32'd29);
    repeat (5) @(posedge clk);
    #1;
    check("mul_hold", result, 32'h4040_0000);

    run(2'b10, 32'hBFC0_0000, 32'h4000_0000, 0, lat, bz1, bzd);
    check("mul_neg", result, 32'hC040_0000);

    run(2'b01, 32'h4040_0000, 32'h3F80_0000, 0, lat, bz1, bzd);
    check("sub_res", result, 32'h4000_0000);
    run(2'b01, 32'h3F80_0000, 32'h3F80_0000, 0, lat, bz1, bzd);
    check("sub_zero", result, 32'h0000_0000);

    run(2'b00, 32'h3F80_0000, 32'h3380_0000, 0, lat, bz1, bzd);
    check("rnd_tie", result, 32'h3F80_0000);
    check("rnd_lat", 32'(lat), 32'd6);
    run(2'b00, 32'h3F80_0000, 32'h33C0_0000, 0, lat, bz1, bzd);
    check("rnd_up", result, 32'h3F80_0001);

    run(2'b10, 32'h7F00_0000, 32'h7F00_0000, 0, lat, bz1, bzd);
    check("ovf_res", result, 32'h7F80_0000);
    check("ovf_flag", 32'(overflow), 32'd1);
    run(2'b10, 32'h0080_0000, 32'h0080_0000, 0, lat, bz1, bzd);
    check("unf_res", result, 32'h0000_0000);
    check("unf_flag", 32'(underflow), 32'd1);
    check("unf_ovf", 32'(overflow), 32'd0);

    run(2'b10, 32'h0000_0000, 32'h4000_0000, 0, lat, bz1, bzd);
    check("zero_res", result, 32'h0000_0000);
    check("zero_lat", 32'(lat), 32'd3);
    check("zero_unf", 32'(underflow), 32'd0);

    run(2'b00, 32'h7F80_0000, 32'h3F80_0000, 0, lat, bz1, bzd);
    check("inf_res", result, 32'h7F80_0000);
    check("inf_ovf", 32'(overflow), 32'd1);

    run(2'b11, 32'h3F80_0000, 32'h3F80_0000, 0, lat, bz1, bzd);
    check("op3_add", result, 32'h4000_0000);

    run(2'b10, 32'h3FC0_0000, 32'h4000_0000, 5, lat, bz1, bzd);
    check("busy_res", result, 32'h4040_0000);
    check("busy_lat", 32'(lat), 32'd29);
    count_done(40, nd);
    check("busy_once", 32'(nd), 32'd0);

    @(posedge clk); #1;
    op = 2'b10; a = 32'h3FC0_0000; b = 32'h4000_0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_res", result, 32'h0);
    count_done(40, nd);
    check("abort_nodone", 32'(nd), 32'd0);

    run(2'b00, 32'h3F80_0000, 32'h3F80_0000, 0, lat, bz1, bzd);
    check("post_add", result, 32'h4000_0000);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
